// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
// Shared constants for the register scoreboard: default register count,
// default register-number width and the drain FSM state encoding.
package reg_scoreboard_pkg;

    localparam int NREG_DEF   = 16;
    localparam int RNUM_W_DEF = 4;

    // Drain/handshake FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ACK   = 2'd2
    } sb_state_e;

endpackage

// File: rtl/reg_scoreboard_dec_onehot.sv
// dec_onehot
// Enable-gated binary to one-hot decoder.
// Ports:
//   en_i      - when low the output is all zeros
//   idx_i     - binary index, IN_W bits
//   onehot_o  - OUT_W-bit one-hot result (bit idx_i set when en_i)
module dec_onehot #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic             en_i,
    input  logic [IN_W-1:0]  idx_i,
    output logic [OUT_W-1:0] onehot_o
);

    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_bit
            assign onehot_o[gi] = en_i && (idx_i == IN_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Tracks which general registers have a write outstanding between issue and
// write-back, stalls issue on RAW/WAW hazards, and provides a drain handshake
// (sync_req / sync_ack) that waits until no reservation remains.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   issue_v, issue_wb, issue_rd    - offered instruction, writes flag, dest
//   issue_rs0/1, issue_rs0/1_use   - source registers and their use flags
//   flush                          - squashes the offered instruction
//   issue_stall                    - ID must hold its instruction (combinational)
//   wb, wbr_num                    - write-back release
//   sync_req, sync_ack             - drain request (level) / done pulse
//   reserved, inflight             - registered reservation vector / popcount
//   err                            - sticky: release of an unreserved register
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int RNUM_W = RNUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_v,
    input  logic              issue_wb,
    input  logic [RNUM_W-1:0] issue_rd,
    input  logic [RNUM_W-1:0] issue_rs0,
    input  logic [RNUM_W-1:0] issue_rs1,
    input  logic              issue_rs0_use,
    input  logic              issue_rs1_use,
    input  logic              flush,
    output logic              issue_stall,
    input  logic              wb,
    input  logic [RNUM_W-1:0] wbr_num,
    input  logic              sync_req,
    output logic              sync_ack,
    output logic [NREG-1:0]   reserved,
    output logic [RNUM_W:0]   inflight,
    output logic              err
);

    sb_state_e          state_q, state_d;
    logic [NREG-1:0]    reserved_q, reserved_d;
    logic [RNUM_W:0]    inflight_q, inflight_d;
    logic               err_q, err_d;

    logic [NREG-1:0]    rel_mask;
    logic [NREG-1:0]    set_mask;
    logic [NREG-1:0]    res_eff;
    logic               hazard;
    logic               issue_accept;
    logic               set_any;
    logic               clr_any;

    // Release mask: the register being written back this cycle.
    dec_onehot #(.IN_W(RNUM_W), .OUT_W(NREG)) u_dec_rel (
        .en_i     (wb),
        .idx_i    (wbr_num),
        .onehot_o (rel_mask)
    );

    // Set mask: destination of an instruction actually leaving ID.
    dec_onehot #(.IN_W(RNUM_W), .OUT_W(NREG)) u_dec_set (
        .en_i     (issue_accept & issue_wb),
        .idx_i    (issue_rd),
        .onehot_o (set_mask)
    );

    // A write-back in the same cycle already resolves its hazard.
    assign res_eff = reserved_q & ~rel_mask;

    assign hazard = (issue_rs0_use & res_eff[issue_rs0])
                  | (issue_rs1_use & res_eff[issue_rs1])
                  | (issue_wb      & res_eff[issue_rd]);

    // Any non-IDLE state blocks issue, and so does a fresh request in IDLE,
    // so nothing new gets reserved once a drain has been asked for.
    assign issue_stall  = issue_v & (hazard | (state_q != ST_IDLE) | sync_req);
    assign issue_accept = issue_v & ~issue_stall & ~flush;

    // An accepted set never targets a register that stays reserved (WAW
    // stalls), so the set and an effective clear can only coincide on the
    // same register, which nets to zero.
    assign set_any = |set_mask;
    assign clr_any = |(rel_mask & reserved_q);

    always_comb begin
        reserved_d = (reserved_q & ~rel_mask) | set_mask;
        inflight_d = inflight_q + (RNUM_W+1)'(set_any) - (RNUM_W+1)'(clr_any);
        err_d      = err_q | (wb & ~reserved_q[wbr_num]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reserved_q <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            reserved_q <= reserved_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (sync_req)           state_d = ST_DRAIN;
            ST_DRAIN: if (reserved_q == '0)   state_d = ST_ACK;
            ST_ACK:                           state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. Gated by rst so a reset landing on ACK emits no pulse.
    always_comb begin
        sync_ack = (state_q == ST_ACK) & ~rst;
    end

    assign reserved = reserved_q;
    assign inflight = inflight_q;
    assign err      = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    localparam int NREG   = 16;
    localparam int RNUM_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              issue_v;
    logic              issue_wb;
    logic [RNUM_W-1:0] issue_rd;
    logic [RNUM_W-1:0] issue_rs0;
    logic [RNUM_W-1:0] issue_rs1;
    logic              issue_rs0_use;
    logic              issue_rs1_use;
    logic              flush;
    logic              issue_stall;
    logic              wb;
    logic [RNUM_W-1:0] wbr_num;
    logic              sync_req;
    logic              sync_ack;
    logic [NREG-1:0]   reserved;
    logic [RNUM_W:0]   inflight;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.NREG(NREG), .RNUM_W(RNUM_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_v       (issue_v),
        .issue_wb      (issue_wb),
        .issue_rd      (issue_rd),
        .issue_rs0     (issue_rs0),
        .issue_rs1     (issue_rs1),
        .issue_rs0_use (issue_rs0_use),
        .issue_rs1_use (issue_rs1_use),
        .flush         (flush),
        .issue_stall   (issue_stall),
        .wb            (wb),
        .wbr_num       (wbr_num),
        .sync_req      (sync_req),
        .sync_ack      (sync_ack),
        .reserved      (reserved),
        .inflight      (inflight),
        .err           (err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %-14s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %-14s got=%0h (t=%0t)", tag, got, $time);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_in();
        issue_v       = 1'b0;
        issue_wb      = 1'b0;
        issue_rd      = '0;
        issue_rs0     = '0;
        issue_rs1     = '0;
        issue_rs0_use = 1'b0;
        issue_rs1_use = 1'b0;
        flush         = 1'b0;
        wb            = 1'b0;
        wbr_num       = '0;
        sync_req      = 1'b0;
    endtask

    task automatic offer_write(input logic [RNUM_W-1:0] rd);
        issue_v  = 1'b1;
        issue_wb = 1'b1;
        issue_rd = rd;
    endtask

    initial begin
        idle_in();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_val("rst_reserved", 32'(reserved), 32'h0);
        check_val("rst_inflight", 32'(inflight), 32'h0);
        check_val("rst_err",      32'(err),      32'h0);
        check_val("rst_ack",      32'(sync_ack), 32'h0);
        check_val("rst_stall",    32'(issue_stall), 32'h0);

        // RAW on r3
        offer_write(4'd3);
        settle();
        check_val("raw_iss_stall", 32'(issue_stall), 32'h0);
        tick();
        check_val("raw_res_set",  32'(reserved), 32'h0008);
        check_val("raw_infl1",    32'(inflight), 32'h1);
        idle_in();
        issue_v = 1'b1; issue_rs0 = 4'd3; issue_rs0_use = 1'b1;
        settle();
        check_val("raw_stall_a",  32'(issue_stall), 32'h1);
        tick();
        check_val("raw_stall_b",  32'(issue_stall), 32'h1);
        wb = 1'b1; wbr_num = 4'd3;
        settle();
        check_val("raw_wb_stall", 32'(issue_stall), 32'h0);
        tick();
        idle_in();
        check_val("raw_res_clr",  32'(reserved), 32'h0);
        check_val("raw_infl0",    32'(inflight), 32'h0);

        // Flush squashes the issue
        offer_write(4'd5);
        flush = 1'b1;
        tick();
        idle_in();
        check_val("flush_res",    32'(reserved), 32'h0);
        check_val("flush_infl",   32'(inflight), 32'h0);

        // WAW and same-cycle set/clear on r7
        offer_write(4'd7);
        tick();
        check_val("waw_res",      32'(reserved), 32'h0080);
        offer_write(4'd7);
        settle();
        check_val("waw_stall",    32'(issue_stall), 32'h1);
        wb = 1'b1; wbr_num = 4'd7;
        settle();
        check_val("sim_stall",    32'(issue_stall), 32'h0);
        tick();
        idle_in();
        check_val("sim_res",      32'(reserved), 32'h0080);
        check_val("sim_infl",     32'(inflight), 32'h1);
        check_val("sim_err",      32'(err),      32'h0);
        wb = 1'b1; wbr_num = 4'd7;
        tick();
        idle_in();
        check_val("r7_rel_res",   32'(reserved), 32'h0);
        check_val("r7_rel_infl",  32'(inflight), 32'h0);

        // Drain with r2 and r9 outstanding
        offer_write(4'd2);
        tick();
        offer_write(4'd9);
        tick();
        idle_in();
        check_val("drn_res",      32'(reserved), 32'h0204);
        check_val("drn_infl",     32'(inflight), 32'h2);
        sync_req = 1'b1;
        issue_v  = 1'b1;
        settle();
        check_val("drn_idle_stl", 32'(issue_stall), 32'h1);
        tick();
        check_val("drn_stall0",   32'(issue_stall), 32'h1);
        check_val("drn_ack0",     32'(sync_ack), 32'h0);
        wb = 1'b1; wbr_num = 4'd2;
        tick();
        check_val("drn_res_r9",   32'(reserved), 32'h0200);
        check_val("drn_ack1",     32'(sync_ack), 32'h0);
        wb = 1'b1; wbr_num = 4'd9;
        tick();
        wb = 1'b0;
        check_val("drn_res_0",    32'(reserved), 32'h0);
        check_val("drn_ack2",     32'(sync_ack), 32'h0);
        check_val("drn_stall1",   32'(issue_stall), 32'h1);
        tick();
        sync_req = 1'b0;
        check_val("drn_ack_hi",   32'(sync_ack), 32'h1);
        tick();
        check_val("drn_ack_lo",   32'(sync_ack), 32'h0);
        settle();
        check_val("drn_idle",     32'(issue_stall), 32'h0);
        idle_in();

        // Release of an unreserved register
        wb = 1'b1; wbr_num = 4'd0;
        tick();
        idle_in();
        check_val("err_set",      32'(err),      32'h1);
        check_val("err_res",      32'(reserved), 32'h0);
        check_val("err_infl",     32'(inflight), 32'h0);
        tick();
        tick();
        check_val("err_sticky",   32'(err),      32'h1);

        // Reset in the middle of a drain
        offer_write(4'd4);
        tick();
        idle_in();
        check_val("mid_res",      32'(reserved), 32'h0010);
        sync_req = 1'b1;
        tick();
        tick();
        check_val("mid_ack0",     32'(sync_ack), 32'h0);
        rst = 1'b1;
        settle();
        check_val("mid_ack_rst",  32'(sync_ack), 32'h0);
        tick();
        rst = 1'b0;
        sync_req = 1'b0;
        check_val("mid_res0",     32'(reserved), 32'h0);
        check_val("mid_infl0",    32'(inflight), 32'h0);
        check_val("mid_err0",     32'(err),      32'h0);
        check_val("mid_ack1",     32'(sync_ack), 32'h0);
        issue_v = 1'b1;
        settle();
        check_val("mid_idle",     32'(issue_stall), 32'h0);
        tick();
        idle_in();
        check_val("mid_ack2",     32'(sync_ack), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
